// File: rtl/divider_pkg.sv
// ============================================================================
// divider_pkg : state encoding and default widths for divider_param. Rev 1.0
// ============================================================================
`default_nettype none

package divider_pkg;
  localparam int c_DEF_DIVIDEND_W = 8;
  localparam int c_DEF_DIVISOR_W  = 7;

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_ITER = 2'd1;
  localparam logic [1:0] c_FIX  = 2'd2;
  localparam logic [1:0] c_DONE = 2'd3;
endpackage

`default_nettype wire

// File: rtl/divider_step.sv
// ============================================================================
// divider_step : one combinational restoring shift/compare/subtract stage. Rev 1.0
// ============================================================================
`default_nettype none

module divider_step
  import divider_pkg::*;
#(
  parameter int DIVISOR_W = c_DEF_DIVISOR_W
) (
  input  logic [DIVISOR_W:0]   i_rem,
  input  logic                 i_bit,
  input  logic [DIVISOR_W-1:0] i_divisor,
  output logic [DIVISOR_W:0]   o_rem,
  output logic                 o_qbit
);

  logic [DIVISOR_W+1:0] w_shift;
  logic [DIVISOR_W+1:0] w_dsr;

  assign w_shift = {i_rem, i_bit};
  assign w_dsr   = {2'b00, i_divisor};
  assign o_qbit  = (w_shift >= w_dsr);
  assign o_rem   = o_qbit ? (DIVISOR_W+1)'(w_shift - w_dsr) : w_shift[DIVISOR_W:0];

endmodule

`default_nettype wire

// File: rtl/divider_param.sv
// ============================================================================
// divider_param : iterative signed/unsigned restoring divider, one bit/cycle. Rev 1.0
// ============================================================================
`default_nettype none

module divider_param
  import divider_pkg::*;
#(
  parameter int DIVIDEND_W = c_DEF_DIVIDEND_W,
  parameter int DIVISOR_W  = c_DEF_DIVISOR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividendin,
  input  logic [DIVISOR_W-1:0]  divisorin,
  input  logic                  signed_mode,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  valid,
  output logic                  busy,
  output logic                  dbz,
  output logic                  ovf,
  output logic [1:0]            state_w
);

  localparam int CNT_W = $clog2(DIVIDEND_W + 1);

  logic [1:0]            r_state;
  logic [1:0]            w_next;
  logic [CNT_W-1:0]      r_cnt;
  logic [DIVIDEND_W-1:0] r_dvd;
  logic [DIVISOR_W-1:0]  r_dsr;
  logic [DIVISOR_W:0]    r_prem;
  logic                  r_q_neg;
  logic                  r_r_neg;
  logic                  r_dbz_p;
  logic                  r_ovf_p;

  logic                  w_accept;
  logic                  w_dvd_neg;
  logic                  w_dsr_neg;
  logic [DIVIDEND_W-1:0] w_dvd_mag;
  logic [DIVISOR_W-1:0]  w_dsr_mag;
  logic [DIVISOR_W:0]    w_step_rem;
  logic                  w_step_q;
  logic [DIVIDEND_W-1:0] w_q_fix;
  logic [DIVISOR_W-1:0]  w_r_mag;
  logic [DIVISOR_W-1:0]  w_r_fix;

  assign w_accept  = start && (r_state == c_IDLE || r_state == c_DONE);
  // Magnitudes are unsigned, so the most-negative value maps to 2^(W-1) exactly.
  assign w_dvd_neg = signed_mode & dividendin[DIVIDEND_W-1];
  assign w_dsr_neg = signed_mode & divisorin[DIVISOR_W-1];
  assign w_dvd_mag = w_dvd_neg ? -dividendin : dividendin;
  assign w_dsr_mag = w_dsr_neg ? -divisorin : divisorin;

  divider_step #(.DIVISOR_W(DIVISOR_W)) u_step (
    .i_rem     (r_prem),
    .i_bit     (r_dvd[DIVIDEND_W-1]),
    .i_divisor (r_dsr),
    .o_rem     (w_step_rem),
    .o_qbit    (w_step_q)
  );

  assign w_r_mag = r_prem[DIVISOR_W-1:0];
  assign w_q_fix = r_dbz_p ? '1 : (r_q_neg ? -r_dvd : r_dvd);
  assign w_r_fix = r_dbz_p ? '0 : (r_r_neg ? -w_r_mag : w_r_mag);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= c_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE, c_DONE: if (start) w_next = c_ITER;
      c_ITER:         if (r_cnt == '0) w_next = c_FIX;
      c_FIX:          w_next = c_DONE;
      default:        w_next = c_IDLE;
    endcase
  end

  always_comb begin
    busy    = (r_state == c_ITER) || (r_state == c_FIX);
    state_w = r_state;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt     <= '0;
      r_dvd     <= '0;
      r_dsr     <= '0;
      r_prem    <= '0;
      r_q_neg   <= 1'b0;
      r_r_neg   <= 1'b0;
      r_dbz_p   <= 1'b0;
      r_ovf_p   <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      valid     <= 1'b0;
      dbz       <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt   <= CNT_W'(DIVIDEND_W);
        r_dvd   <= w_dvd_mag;
        r_dsr   <= w_dsr_mag;
        r_prem  <= '0;
        r_q_neg <= w_dvd_neg ^ w_dsr_neg;
        r_r_neg <= w_dvd_neg;
        r_dbz_p <= (divisorin == '0);
        r_ovf_p <= signed_mode && (dividendin == {1'b1, {(DIVIDEND_W-1){1'b0}}})
                   && (&divisorin);
        valid   <= 1'b0;
        dbz     <= 1'b0;
        ovf     <= 1'b0;
      end else if (r_state == c_ITER && r_cnt != '0) begin
        r_prem <= w_step_rem;
        r_dvd  <= {r_dvd[DIVIDEND_W-2:0], w_step_q};
        r_cnt  <= r_cnt - 1'b1;
      end else if (r_state == c_FIX) begin
        quotient  <= w_q_fix;
        remainder <= w_r_fix;
        valid     <= 1'b1;
        dbz       <= r_dbz_p;
        ovf       <= r_ovf_p;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/divider_param.md
DIVIDER_PARAM -- requirements
Module: divider_param

Interface
REQ-001 Parameter DIVIDEND_W, default 8: dividend and quotient width; SHALL be legal from 4 to 32.
REQ-002 Parameter DIVISOR_W, default 7: divisor and remainder width; SHALL satisfy 2 <= DIVISOR_W <= DIVIDEND_W.
REQ-003 Port clk, input, 1: single clock; all state SHALL update on the rising edge.
REQ-004 Port reset, input, 1: reset is asynchronous and active-high.
REQ-005 Port start, input, 1: request; SHALL be sampled on the rising edge.
REQ-006 Port dividendin, input, DIVIDEND_W: dividend; SHALL be captured on the same edge as start.
REQ-007 Port divisorin, input, DIVISOR_W: divisor; SHALL be captured on the same edge as start.
REQ-008 Port signed_mode, input, 1: 1 = two's-complement operands; SHALL be captured with start.
REQ-009 Port quotient, output, DIVIDEND_W: result quotient.
REQ-010 Port remainder, output, DIVISOR_W: result remainder.
REQ-011 Port valid, output, 1: result outputs are meaningful.
REQ-012 Port busy, output, 1: operation in progress; start is ignored while it is high.
REQ-013 Port dbz, output, 1: divide-by-zero flag, qualified by valid.
REQ-014 Port ovf, output, 1: signed-overflow flag, qualified by valid.
REQ-015 Port state_w, output, 2: debug copy of the FSM state.

Function
REQ-016 FSM states: IDLE=0, ITER=1, FIX=2, DONE=3.
REQ-017 IDLE or DONE with start=1: capture operands and mode; clear valid, dbz and ovf; go to ITER; load the iteration counter with DIVIDEND_W.
REQ-018 ITER: one restoring step per cycle, MSB first, one quotient bit per cycle; go to FIX when the counter reaches 0.
REQ-019 FIX: apply the result signs; set valid and the flags; go to DONE.
REQ-020 DONE: hold all outputs stable until the next accepted start or reset.
REQ-021 Latency: valid SHALL rise exactly DIVIDEND_W+2 rising edges after the start edge (10 at default), identically for every case including dbz and ovf.
REQ-022 busy SHALL be 1 in ITER and FIX, and 0 in IDLE and DONE.
REQ-023 start in ITER or FIX SHALL be ignored with no side effects; start in DONE SHALL be accepted (back-to-back operation).
REQ-024 Unsigned mode: quotient = floor(dividend/divisor); remainder = dividend mod divisor.
REQ-025 Signed mode: operate on magnitudes; quotient truncates toward zero; remainder takes the sign of the dividend or is 0.
REQ-026 Arithmetic: partial remainder register width is DIVISOR_W+1 bits; magnitudes use unsigned DIVIDEND_W / DIVISOR_W bits, with no loss at the most-negative value.
REQ-027 Divisor = 0: dbz=1, quotient = all ones, remainder = 0, ovf=0.
REQ-028 Signed mode with dividend = -2^(DIVIDEND_W-1) and divisor = -1: ovf=1, quotient = -2^(DIVIDEND_W-1) (wrapped), remainder = 0.

Reset
REQ-029 While reset=1: state=IDLE; quotient, remainder, valid, busy, dbz and ovf SHALL all be 0; counter SHALL be 0.
REQ-030 Reset mid-operation SHALL abandon the operation with no result; the first start after reset deasserts SHALL operate normally.

Structure
REQ-031 Shared package divider_pkg SHALL hold the state encoding constants and the default widths.
REQ-032 Sub-module divider_step SHALL be the single combinational restoring subtract/compare stage instantiated by divider_param.
REQ-033 Sign conditioning, counter and FSM SHALL reside in divider_param; quotient and remainder SHALL be registered outputs.

Verification (DIVIDEND_W=8, DIVISOR_W=7)
REQ-034 Unsigned 200/7, start at edge k -> valid at edge k+10; quotient=28, remainder=4; busy high on edges k+1 to k+9.
REQ-035 Signed 0x9C(-100)/0x07 -> quotient=0xF2(-14), remainder=0x7E(-2), ovf=0, dbz=0.
REQ-036 55/0 -> valid at k+10, dbz=1, quotient=0xFF, remainder=0.
REQ-037 Signed 0x80/0x7F(-1) -> ovf=1, quotient=0x80, remainder=0.
REQ-038 start pulsed at k+4 during 100/9 -> ignored, result 11 rem 1; start in DONE with 9/3 -> valid drops at that edge, result 3 rem 0 ten edges later.
REQ-039 reset asserted at k+5 -> all outputs 0 and state_w=0 immediately; next 17/5 -> 3 rem 2.
